// File: rtl/ctr_frame_packer.sv
// ctr_frame_packer: collects 128-bit ciphertext blocks into one wide frame
// (first block in the MSBs), latches the key/IV seen with the first block,
// and holds the finished frame until the downstream CTR stage takes it.
module ctr_frame_packer #(
  parameter int CIPHERTEXTIN = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [127:0]                          s_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic                                  s_last,
  input  logic [255:0]                          key_in,
  input  logic [127:0]                          iv_in,
  output logic [CIPHERTEXTIN-1:0]               ciphertext_out,
  output logic [255:0]                          key_out,
  output logic [127:0]                          iv_out,
  output logic                                  frame_valid,
  input  logic                                  frame_ready,
  output logic [$clog2(CIPHERTEXTIN/128+1)-1:0] frame_nblk
);

  localparam int NBLK = CIPHERTEXTIN / 128;
  localparam int CW   = $clog2(NBLK + 1);

  localparam logic [CIPHERTEXTIN-1:0] ALL_ONES = '1;
  // Mask covering slot 0 (the top 128 bits); shifted down to reach slot k.
  localparam logic [CIPHERTEXTIN-1:0] TOP_MASK = ~(ALL_ONES >> 128);
  localparam logic [CW-1:0]           LAST_IDX = CW'(NBLK - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CIPHERTEXTIN-1:0] buf_q, buf_d;
  logic [255:0]            key_q, key_d;
  logic [127:0]            iv_q, iv_d;

  logic                    accept;
  logic                    closing;
  logic [CW+6:0]           shamt;
  logic [CIPHERTEXTIN-1:0] slot_mask;
  logic [CIPHERTEXTIN-1:0] slot_data;

  // Next-state logic: accept beats outside HOLD, close on s_last or a full frame
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    key_d   = key_q;
    iv_d    = iv_q;

    accept  = s_valid && (state_q != HOLD);
    closing = accept && (s_last || (cnt_q == LAST_IDX));

    // Slot k starts 128*k bits below the MSB; {cnt, 7'b0} is exactly 128*k.
    shamt     = {cnt_q, 7'd0};
    slot_mask = TOP_MASK >> shamt;
    slot_data = (CIPHERTEXTIN'(s_data) << (CIPHERTEXTIN - 128)) >> shamt;

    if (accept) begin
      buf_d = (buf_q & ~slot_mask) | slot_data;
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          key_d   = key_in;
          iv_d    = iv_in;
          state_d = closing ? HOLD : FILL;
        end
      end
      FILL: begin
        if (accept) begin
          state_d = closing ? HOLD : FILL;
        end
      end
      HOLD: begin
        if (frame_ready) begin
          state_d = IDLE;
          buf_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      key_q   <= '0;
      iv_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      key_q   <= key_d;
      iv_q    <= iv_d;
    end
  end

  assign s_ready        = (state_q != HOLD);
  assign frame_valid    = (state_q == HOLD);
  assign ciphertext_out = buf_q;
  assign key_out        = key_q;
  assign iv_out         = iv_q;
  assign frame_nblk     = cnt_q;

endmodule
